// File: rtl/rr_arbiter_decoded_if.sv
// Request/grant bundle between router inputs and one output-port arbiter.
// The master side raises requests and releases; the slave side arbitrates.
interface rr_arbiter_decoded_if #(
    parameter int SIZE     = 4,
    parameter int LOG_SIZE = 2
);
    logic [SIZE-1:0]     req;
    logic                owner_release;
    logic [SIZE-1:0]     grant;
    logic                grant_valid;
    logic [LOG_SIZE-1:0] grant_enc;

    modport master (
        output req,
        output owner_release,
        input  grant,
        input  grant_valid,
        input  grant_enc
    );

    modport slave (
        input  req,
        input  owner_release,
        output grant,
        output grant_valid,
        output grant_enc
    );
endinterface

// File: rtl/rr_arbiter_decoded.sv
// Packet-locked round-robin arbiter with a registered one-hot grant.
// It also provides the binary index of the grant and a valid flag.
module rr_arbiter_decoded #(
    parameter int SIZE     = 4,
    parameter int LOG_SIZE = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    rr_arbiter_decoded_if.slave  bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state;
    logic [LOG_SIZE-1:0] ptr;
    logic [SIZE-1:0]     cand;
    logic [LOG_SIZE:0]   pick;
    logic                win_any;
    logic [LOG_SIZE-1:0] win_idx;
    logic [SIZE-1:0]     win_hot;

    // Scan from p upward; descending loop lets the nearest hit overwrite.
    function automatic logic [LOG_SIZE:0] arb(
        input logic [SIZE-1:0]     r,
        input logic [LOG_SIZE-1:0] p
    );
        logic                hit;
        logic [LOG_SIZE-1:0] idx;
        logic [LOG_SIZE-1:0] j;
        hit = 1'b0;
        idx = '0;
        for (int k = SIZE - 1; k >= 0; k--) begin
            j = p + LOG_SIZE'(k);
            if (r[j]) begin
                hit = 1'b1;
                idx = j;
            end
        end
        return {hit, idx};
    endfunction

    // Grant is zero in IDLE, so masking the owner is harmless there.
    always_comb begin
        cand    = bus.req & ~bus.grant;
        pick    = arb(cand, ptr);
        win_any = pick[LOG_SIZE];
        win_idx = pick[LOG_SIZE-1:0];
        win_hot = SIZE'(1) << win_idx;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            ptr             <= '0;
            bus.grant       <= '0;
            bus.grant_valid <= 1'b0;
            bus.grant_enc   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_any) begin
                        state           <= LOCKED;
                        ptr             <= win_idx + 1'b1;
                        bus.grant       <= win_hot;
                        bus.grant_valid <= 1'b1;
                        bus.grant_enc   <= win_idx;
                    end
                end
                LOCKED: begin
                    if (bus.owner_release) begin
                        if (win_any) begin
                            ptr             <= win_idx + 1'b1;
                            bus.grant       <= win_hot;
                            bus.grant_valid <= 1'b1;
                            bus.grant_enc   <= win_idx;
                        end else begin
                            state           <= IDLE;
                            bus.grant       <= '0;
                            bus.grant_valid <= 1'b0;
                            bus.grant_enc   <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_arbiter_decoded.sv
// Directed bench for rr_arbiter_decoded with SIZE=4.
// Hand-computed grants plus per-cycle output invariants.
module tb_rr_arbiter_decoded;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rr_arbiter_decoded_if #(.SIZE(4), .LOG_SIZE(2)) bus ();

    rr_arbiter_decoded #(.SIZE(4), .LOG_SIZE(2)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g,
                           input logic [1:0] e);
        chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
        chk({tag, ".valid"}, 32'(bus.grant_valid), 32'(g != 4'b0));
        chk({tag, ".enc"}, 32'(bus.grant_enc), 32'(e));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Invariants on the falling edge, only while out of reset.
    always @(negedge clk) begin
        logic [1:0] idx;
        if (rst_n === 1'b1) begin
            idx = 2'd0;
            for (int i = 0; i < 4; i++)
                if (bus.grant[i] === 1'b1) idx = 2'(i);
            chk("inv.onehot0", 32'($onehot0(bus.grant)), 32'd1);
            chk("inv.valid", 32'(bus.grant_valid), 32'(|bus.grant));
            chk("inv.enc", 32'(bus.grant_enc), 32'(idx));
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        bus.req = 4'b0000;
        bus.owner_release = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("reset", 4'b0000, 2'd0);
        step();
        step();
        rst_n = 1'b1;

        // All request, release every granted cycle: strict rotation.
        bus.req = 4'b1111;
        bus.owner_release = 1'b1;
        step(); chk_out("rot0", 4'b0001, 2'd0);
        step(); chk_out("rot1", 4'b0010, 2'd1);
        step(); chk_out("rot2", 4'b0100, 2'd2);
        step(); chk_out("rot3", 4'b1000, 2'd3);
        step(); chk_out("rot4", 4'b0001, 2'd0);

        // Hand off to owner 3, then wrap to 0.
        bus.req = 4'b1000;
        step(); chk_out("own3", 4'b1000, 2'd3);
        bus.req = 4'b1001;
        step(); chk_out("wrap", 4'b0001, 2'd0);
        bus.req = 4'b0001;
        step(); chk_out("solo_rel", 4'b0000, 2'd0);
        bus.owner_release = 1'b0;
        step(); chk_out("solo_again", 4'b0001, 2'd0);
        bus.req = 4'b0000;
        bus.owner_release = 1'b1;
        step(); chk_out("to_idle", 4'b0000, 2'd0);

        // Single request, grant held with req dropped.
        bus.req = 4'b0100;
        bus.owner_release = 1'b0;
        step(); chk_out("hold_start", 4'b0100, 2'd2);
        bus.req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step(); chk_out("hold", 4'b0100, 2'd2);
        end
        bus.owner_release = 1'b1;
        step(); chk_out("hold_rel", 4'b0000, 2'd0);

        // Release while idle is ignored; ptr still 3.
        step(); chk_out("idle_rel", 4'b0000, 2'd0);
        bus.owner_release = 1'b0;
        bus.req = 4'b0011;
        step(); chk_out("ptr_kept", 4'b0001, 2'd0);
        bus.req = 4'b0010;
        bus.owner_release = 1'b1;
        step(); chk_out("next_1", 4'b0010, 2'd1);
        bus.req = 4'b0000;
        step(); chk_out("idle2", 4'b0000, 2'd0);

        // Reset while locked on owner 2 restores ptr to 0.
        bus.owner_release = 1'b0;
        bus.req = 4'b0100;
        step(); chk_out("lock2", 4'b0100, 2'd2);
        bus.req = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 4'b0000, 2'd0);
        step();
        chk_out("in_rst", 4'b0000, 2'd0);
        rst_n = 1'b1;
        #1;
        chk_out("post_rst", 4'b0000, 2'd0);
        step(); chk_out("first_after", 4'b0001, 2'd0);
        step(); chk_out("held_after", 4'b0001, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
